// File: rtl/gol_vram_dbuf.sv
// Double-buffered Game-of-Life video RAM: Avalon port on the back bank, VGA port on the front bank.
// Frame-synchronised bank swap and a hardware clear engine that zeroes the back bank.
module gol_vram_dbuf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   avl_addr,
  input  logic [DATA_W-1:0]   avl_wdata,
  input  logic [DATA_W/8-1:0] avl_byteen,
  input  logic                avl_rden,
  input  logic                avl_wren,
  output logic [DATA_W-1:0]   avl_rdata,
  output logic                avl_rvalid,
  output logic                avl_waitreq,
  input  logic [ADDR_W-1:0]   vga_addr,
  input  logic                vga_rden,
  output logic [DATA_W-1:0]   vga_rdata,
  input  logic                frame_start,
  input  logic                swap_req,
  input  logic                clear_req,
  output logic                swap_done,
  output logic                clear_busy,
  output logic                front_bank
);

  localparam int BE_W      = DATA_W / 8;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MEM_WORDS = 2 << IDX_W;
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              front_q, front_d;
  logic              pending_q, pending_d;
  logic              swap_done_q, swap_done_d;
  logic              avl_rvalid_q, avl_rvalid_d;
  logic [DATA_W-1:0] avl_rdata_q, avl_rdata_d;
  logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;

  logic              busy, do_swap, avl_in_rng, vga_in_rng;
  logic [IDX_W:0]    avl_idx, vga_idx, mem_widx;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdat;
  logic [BE_W-1:0]   mem_wbe;

  always_comb begin
    busy       = (state_q == S_CLEAR);
    avl_in_rng = ({1'b0, avl_addr} < DEPTH_L);
    vga_in_rng = ({1'b0, vga_addr} < DEPTH_L);
    avl_idx    = {~front_q, avl_addr[IDX_W-1:0]};
    vga_idx    = {front_q, vga_addr[IDX_W-1:0]};

    // A swap is only allowed while idle, so the clear always targets one stable bank.
    do_swap     = frame_start && (pending_q || swap_req) && !busy;
    front_d     = front_q ^ do_swap;
    pending_d   = do_swap ? 1'b0 : (pending_q | swap_req);
    swap_done_d = do_swap;

    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (!busy) begin
      if (clear_req) begin
        state_d   = S_CLEAR;
        clr_cnt_d = '0;
      end
    end else if (clr_cnt_q == LAST_IDX) begin
      state_d   = S_IDLE;
      clr_cnt_d = '0;
    end else begin
      clr_cnt_d = clr_cnt_q + 1'b1;
    end

    mem_we   = 1'b0;
    mem_widx = avl_idx;
    mem_wdat = avl_wdata;
    mem_wbe  = avl_byteen;
    if (busy) begin
      mem_we   = 1'b1;
      mem_widx = {~front_q, clr_cnt_q};
      mem_wdat = '0;
      mem_wbe  = '1;
    end else if (avl_wren && avl_in_rng) begin
      mem_we = 1'b1;
    end

    // Reads sample the array before this edge's write lands: read-before-write.
    avl_rvalid_d = avl_rden && !busy;
    avl_rdata_d  = avl_rdata_q;
    if (avl_rvalid_d) avl_rdata_d = avl_in_rng ? mem[avl_idx] : '0;

    vga_rdata_d = vga_rdata_q;
    if (vga_rden) vga_rdata_d = vga_in_rng ? mem[vga_idx] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      clr_cnt_q    <= '0;
      front_q      <= 1'b0;
      pending_q    <= 1'b0;
      swap_done_q  <= 1'b0;
      avl_rvalid_q <= 1'b0;
      avl_rdata_q  <= '0;
      vga_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      front_q      <= front_d;
      pending_q    <= pending_d;
      swap_done_q  <= swap_done_d;
      avl_rvalid_q <= avl_rvalid_d;
      avl_rdata_q  <= avl_rdata_d;
      vga_rdata_q  <= vga_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (mem_we && mem_wbe[i]) mem[mem_widx][8*i +: 8] <= mem_wdat[8*i +: 8];
    end
  end

  assign avl_rdata   = avl_rdata_q;
  assign avl_rvalid  = avl_rvalid_q;
  assign avl_waitreq = busy;
  assign vga_rdata   = vga_rdata_q;
  assign swap_done   = swap_done_q;
  assign clear_busy  = busy;
  assign front_bank  = front_q;

endmodule

// File: tb/tb_gol_vram_dbuf.sv
// Directed bench for gol_vram_dbuf with DEPTH=16: byte enables, swap, clear, reset and bounds.
module tb_gol_vram_dbuf;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] avl_addr = '0;
  logic [DATA_W-1:0] avl_wdata = '0;
  logic [3:0]        avl_byteen = '0;
  logic              avl_rden = 1'b0, avl_wren = 1'b0;
  logic [DATA_W-1:0] avl_rdata;
  logic              avl_rvalid, avl_waitreq;
  logic [ADDR_W-1:0] vga_addr = '0;
  logic              vga_rden = 1'b0;
  logic [DATA_W-1:0] vga_rdata;
  logic              frame_start = 1'b0, swap_req = 1'b0, clear_req = 1'b0;
  logic              swap_done, clear_busy, front_bank;

  int checks = 0;
  int errors = 0;

  gol_vram_dbuf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_byteen(avl_byteen),
    .avl_rden(avl_rden), .avl_wren(avl_wren), .avl_rdata(avl_rdata),
    .avl_rvalid(avl_rvalid), .avl_waitreq(avl_waitreq),
    .vga_addr(vga_addr), .vga_rden(vga_rden), .vga_rdata(vga_rdata),
    .frame_start(frame_start), .swap_req(swap_req), .clear_req(clear_req),
    .swap_done(swap_done), .clear_busy(clear_busy), .front_bank(front_bank)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: all start and end at a falling edge.
  task automatic avl_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    avl_addr = a; avl_wdata = d; avl_byteen = be; avl_wren = 1'b1;
    @(negedge clk);
    avl_wren = 1'b0; avl_byteen = '0;
  endtask

  task automatic avl_read(input logic [7:0] a, output logic [31:0] d, output logic v);
    avl_addr = a; avl_rden = 1'b1;
    @(negedge clk);
    avl_rden = 1'b0;
    d = avl_rdata; v = avl_rvalid;
  endtask

  task automatic vga_read(input logic [7:0] a, output logic [31:0] d);
    vga_addr = a; vga_rden = 1'b1;
    @(negedge clk);
    vga_rden = 1'b0;
    d = vga_rdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Zero both banks (memory has no reset), then reset so front_bank=0.
  task automatic init_mem;
    reset = 1'b0;
    clear_req = 1'b1; @(negedge clk); clear_req = 1'b0;
    idle(18);
    swap_req = 1'b1; frame_start = 1'b1; @(negedge clk);
    swap_req = 1'b0; frame_start = 1'b0;
    clear_req = 1'b1; @(negedge clk); clear_req = 1'b0;
    idle(18);
    reset = 1'b1;
    idle(1);
  endtask

  task automatic test_reset;
    checks++;
    if ({front_bank, clear_busy, avl_waitreq, avl_rvalid, swap_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b required 00000",
               {front_bank, clear_busy, avl_waitreq, avl_rvalid, swap_done});
    end
    checks++;
    if (avl_rdata !== 32'h0 || vga_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data avl=%h vga=%h required 0", avl_rdata, vga_rdata);
    end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_byte_enables;
    logic [31:0] d; logic v;
    avl_write(5, 32'hFFFF_FFFF, 4'hF);
    avl_write(5, 32'h1234_5678, 4'b0101);
    avl_read(5, d, v);
    checks++;
    if (d !== 32'hFF34_FF78 || v !== 1'b1) begin
      errors++; $display("FAIL byteen_read got %h v=%b required ff34ff78 v=1", d, v);
    end
    idle(1);
    checks++;
    if (avl_rvalid !== 1'b0 || avl_rdata !== 32'hFF34_FF78) begin
      errors++; $display("FAIL rvalid_pulse got v=%b d=%h required v=0 d=ff34ff78", avl_rvalid, avl_rdata);
    end
    avl_write(5, 32'h0, 4'h0);
    avl_addr = 5; avl_wdata = 32'hDEAD_BEEF; avl_byteen = 4'hF; avl_rden = 1'b1; avl_wren = 1'b1;
    @(negedge clk);
    avl_rden = 1'b0; avl_wren = 1'b0; avl_byteen = '0;
    checks++;
    if (avl_rdata !== 32'hFF34_FF78) begin
      errors++; $display("FAIL read_before_write got %h required ff34ff78", avl_rdata);
    end
    avl_read(5, d, v);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rbw_new_data got %h required deadbeef", d);
    end
  endtask

  task automatic test_swap;
    logic [31:0] d; logic v;
    avl_write(10, 32'hA5A5_A5A5, 4'hF);
    vga_read(10, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL bank_isolation got %h required 0", d);
    end
    swap_req = 1'b1; @(negedge clk); swap_req = 1'b0;
    idle(19);
    checks++;
    if (front_bank !== 1'b0 || swap_done !== 1'b0) begin
      errors++; $display("FAIL swap_wait got fb=%b sd=%b required 0 0", front_bank, swap_done);
    end
    frame_start = 1'b1; vga_addr = 10; vga_rden = 1'b1;
    @(negedge clk);
    frame_start = 1'b0; vga_rden = 1'b0;
    checks++;
    if (front_bank !== 1'b1 || swap_done !== 1'b1 || vga_rdata !== 32'h0) begin
      errors++;
      $display("FAIL swap_edge got fb=%b sd=%b vga=%h required 1 1 0", front_bank, swap_done, vga_rdata);
    end
    idle(1);
    checks++;
    if (swap_done !== 1'b0) begin
      errors++; $display("FAIL swap_done_pulse got %b required 0", swap_done);
    end
    vga_read(10, d);
    checks++;
    if (d !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL swap_vga got %h required a5a5a5a5", d);
    end
    avl_read(10, d, v);
    checks++;
    if (d !== 32'h0 || v !== 1'b1) begin
      errors++; $display("FAIL swap_avl_back got %h v=%b required 0 v=1", d, v);
    end
  endtask

  task automatic test_simultaneous;
    avl_write(3, 32'h0BAD_F00D, 4'hF);
    swap_req = 1'b1; frame_start = 1'b1; @(negedge clk);
    swap_req = 1'b0; frame_start = 1'b0;
    checks++;
    if (front_bank !== 1'b0 || swap_done !== 1'b1) begin
      errors++; $display("FAIL same_cycle_swap got fb=%b sd=%b required 0 1", front_bank, swap_done);
    end
    idle(1);
    frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
    checks++;
    if (front_bank !== 1'b0 || swap_done !== 1'b0) begin
      errors++; $display("FAIL idle_frame_start got fb=%b sd=%b required 0 0", front_bank, swap_done);
    end
  endtask

  task automatic test_clear;
    logic [31:0] d; logic v;
    int n, bad_wait, bad_rv;
    for (int i = 0; i < 16; i++) avl_write(8'(i), 32'(i + 1) * 32'h0101_0101, 4'hF);
    avl_addr = 0; avl_rden = 1'b1; clear_req = 1'b1;
    @(negedge clk);
    avl_rden = 1'b0; clear_req = 1'b0;
    checks++;
    if (avl_rvalid !== 1'b1 || avl_rdata !== 32'h0101_0101) begin
      errors++; $display("FAIL clear_req_access got v=%b d=%h required 1 01010101", avl_rvalid, avl_rdata);
    end
    n = 0; bad_wait = 0; bad_rv = 0;
    while (clear_busy === 1'b1 && n < 100) begin
      n++;
      if (avl_waitreq !== 1'b1) bad_wait++;
      if (n > 1 && avl_rvalid !== 1'b0) bad_rv++;
      avl_addr = 2; avl_wdata = 32'h5555_5555; avl_byteen = 4'hF;
      avl_wren = (n == 10); avl_rden = (n == 10);
      clear_req = (n == 12);
      @(negedge clk);
    end
    avl_wren = 1'b0; avl_rden = 1'b0; clear_req = 1'b0; avl_byteen = '0;
    checks++;
    if (n !== 16) begin
      errors++; $display("FAIL clear_length got %0d cycles required 16", n);
    end
    checks++;
    if (bad_wait !== 0 || bad_rv !== 0 || avl_waitreq !== 1'b0) begin
      errors++;
      $display("FAIL clear_waitreq got bad_wait=%0d bad_rv=%0d waitreq_after=%b required 0 0 0",
               bad_wait, bad_rv, avl_waitreq);
    end
    for (int i = 0; i < 16; i++) begin
      avl_read(8'(i), d, v);
      checks++;
      if (d !== 32'h0 || v !== 1'b1) begin
        errors++; $display("FAIL clear_word%0d got %h v=%b required 0 v=1", i, d, v);
      end
    end
    vga_read(3, d);
    checks++;
    if (d !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL clear_front_intact got %h required 0badf00d", d);
    end
  endtask

  task automatic test_clear_swap;
    logic [31:0] d;
    int n, bad;
    avl_write(7, 32'h1357_9BDF, 4'hF);
    clear_req = 1'b1; @(negedge clk); clear_req = 1'b0;
    n = 0; bad = 0;
    while (clear_busy === 1'b1 && n < 100) begin
      n++;
      if (swap_done !== 1'b0 || front_bank !== 1'b0) bad++;
      swap_req = (n == 2);
      frame_start = (n == 6);
      @(negedge clk);
    end
    swap_req = 1'b0; frame_start = 1'b0;
    checks++;
    if (bad !== 0 || front_bank !== 1'b0 || n !== 16) begin
      errors++; $display("FAIL clear_blocks_swap got bad=%0d fb=%b n=%0d required 0 0 16", bad, front_bank, n);
    end
    frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
    checks++;
    if (front_bank !== 1'b1 || swap_done !== 1'b1) begin
      errors++; $display("FAIL pending_after_clear got fb=%b sd=%b required 1 1", front_bank, swap_done);
    end
    vga_read(7, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL cleared_now_front got %h required 0", d);
    end
  endtask

  task automatic test_reset_bounds;
    logic [31:0] d; logic v;
    int n;
    avl_write(12, 32'hCAFE_BABE, 4'hF);
    clear_req = 1'b1; @(negedge clk); clear_req = 1'b0;
    n = 0;
    while (clear_busy === 1'b1 && n < 5) begin
      n++;
      if (n == 5) break;
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({clear_busy, avl_waitreq, front_bank, avl_rvalid, swap_done} !== 5'b0 ||
        avl_rdata !== 32'h0 || vga_rdata !== 32'h0 || n !== 5) begin
      errors++;
      $display("FAIL reset_mid_clear got flags=%b avl=%h vga=%h n=%0d required 00000 0 0 5",
               {clear_busy, avl_waitreq, front_bank, avl_rvalid, swap_done}, avl_rdata, vga_rdata, n);
    end
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    vga_read(3, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL partial_clear_done got %h required 0", d);
    end
    vga_read(12, d);
    checks++;
    if (d !== 32'hCAFE_BABE) begin
      errors++; $display("FAIL partial_clear_left got %h required cafebabe", d);
    end
    vga_read(16, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL vga_out_of_range got %h required 0", d);
    end
    avl_write(1, 32'h1111_2222, 4'hF);
    avl_write(16, 32'h9999_9999, 4'hF);
    avl_read(0, d, v);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL oor_write_dropped got %h required 0", d);
    end
    avl_read(1, d, v);
    checks++;
    if (d !== 32'h1111_2222) begin
      errors++; $display("FAIL post_reset_write got %h required 11112222", d);
    end
    avl_read(16, d, v);
    checks++;
    if (d !== 32'h0 || v !== 1'b1) begin
      errors++; $display("FAIL avl_out_of_range got %h v=%b required 0 v=1", d, v);
    end
  endtask

  initial begin
    idle(2);
    init_mem;
    test_reset;
    test_byte_enables;
    test_swap;
    test_simultaneous;
    test_clear;
    test_clear_swap;
    test_reset_bounds;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gol_vram_dbuf.md
Name: gol_vram_dbuf

Overview:
- Double-buffered, parametrised video RAM for the Game-of-Life display path.
- Two equal banks:
  - The Avalon (CPU/compute) port always accesses the back bank.
  - The VGA port always reads the front bank.
- Banks swap on request, synchronised to frame start, so the display never shows a half-written generation.
- A hardware clear engine zeroes the back bank without CPU writes.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 13, address width of both ports.
- DEPTH, 8192, words per bank; DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- avl_addr  in  ADDR_W  Avalon word address, back bank.
- avl_wdata  in  DATA_W  Avalon write data.
- avl_byteen  in  DATA_W/8  byte enables; bit i selects byte i (bits 8i+7:8i).
- avl_rden  in  1  Avalon read strobe.
- avl_wren  in  1  Avalon write strobe.
- avl_rdata  out  DATA_W  Avalon read data.
- avl_rvalid  out  1  one-cycle pulse marking avl_rdata valid.
- avl_waitreq  out  1  high while clearing; strobes ignored.
- vga_addr  in  ADDR_W  VGA word address, front bank.
- vga_rden  in  1  VGA read strobe.
- vga_rdata  out  DATA_W  VGA read data.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- swap_req  in  1  pulse: request bank swap at next frame_start.
- clear_req  in  1  pulse: zero the entire back bank.
- swap_done  out  1  one-cycle pulse after a swap takes effect.
- clear_busy  out  1  high during clear.
- front_bank  out  1  index of bank currently displayed.

Behaviour:
- Reset (asynchronous, active-high):
  - front_bank=0, swap_pending=0, FSM=IDLE, clear counter=0.
  - avl_rdata=0, vga_rdata=0; avl_rvalid, swap_done, clear_busy, avl_waitreq all 0.
  - Memory contents are not reset.
- Banks: physical bank index = {bank_bit, addr}.
  - Avalon uses bank ~front_bank.
  - VGA uses front_bank.
- Avalon write (avl_wren=1, avl_waitreq=0, avl_addr<DEPTH):
  - Each enabled byte is written at the clock edge.
  - Disabled bytes are unchanged.
  - avl_byteen=0 writes nothing.
- Avalon read (avl_rden=1, avl_waitreq=0):
  - avl_rdata and avl_rvalid=1 appear on the next cycle (latency 1).
  - avl_rvalid is 0 in all other cycles; avl_rdata holds its last value.
  - Simultaneous rden+wren to the same address returns the old data (read-before-write).
- Out-of-range address (>=DEPTH) on either port: writes dropped; reads return 0 with normal latency/valid.
- VGA read: vga_rden=1 gives vga_rdata on the next cycle; vga_rdata holds while vga_rden=0.
- Same physical word accessed by both ports: cannot occur in normal operation (different banks); no bypass is required.
- Swap:
  - swap_req sets swap_pending; extra swap_req while pending is a no-op.
  - On a cycle with frame_start=1, (swap_pending=1 or swap_req=1), and FSM=IDLE:
    - front_bank toggles at that edge and swap_pending clears.
    - swap_done=1 for the following cycle.
  - frame_start with nothing pending: no effect.
  - Reads issued in the swap cycle use the pre-swap bank mapping.
- Clear FSM, states IDLE and CLEAR:
  - IDLE->CLEAR on clear_req=1; counter=0.
  - In CLEAR, each cycle writes 0 to back-bank word[counter], then counter++.
  - CLEAR->IDLE after writing word DEPTH-1.
  - clear_busy and avl_waitreq are 1 exactly in CLEAR (DEPTH cycles, starting the cycle after clear_req).
  - clear_req in CLEAR is ignored.
  - An Avalon access in the same cycle as clear_req is accepted normally, before the clear begins.
  - frame_start during CLEAR does not swap; swap_pending is retained until a frame_start in IDLE.
  - Reset mid-clear returns to IDLE immediately; the bank is left partially cleared.
  - The VGA port is unaffected by clearing.

Test Plan:
- Byte enables: fill back word 5 = 0xFFFFFFFF; write 0x12345678 with byteen 4'b0101; read -> 0xFF34FF78, avl_rvalid high exactly 1 cycle after rden.
- Bank isolation/swap: write 0xA5A5A5A5 to back addr 10; VGA read addr 10 before swap != 0xA5A5A5A5 (pre-loaded 0); pulse swap_req, then frame_start 20 cycles later -> front_bank=1, swap_done pulse next cycle, VGA addr 10 reads 0xA5A5A5A5.
- Simultaneous events: swap_req and frame_start in same cycle -> swap happens; frame_start with no request -> front_bank unchanged, no swap_done.
- Clear: DEPTH=16, preload back bank with nonzero data, clear_req -> clear_busy/avl_waitreq high 16 cycles, writes ignored during clear, all 16 back words read 0 afterwards, front bank unchanged.
- Clear vs swap: swap_req then frame_start mid-clear -> no swap; next frame_start after clear -> swap + swap_done.
- Reset/bounds: assert reset mid-clear (cycle 5 of 16) -> clear_busy=0, front_bank=0, outputs 0 immediately; read addr DEPTH -> 0 with avl_rvalid.
